rgb_led_arbiter: RTL
====================

// Module: rgb_led_arbiter
// PURPOSE
// Round-robin arbiter sharing one RGB LED (red/green/blue pins) between N_REQ requesters.
// Each requester (e.g. colour-cycling FSM, status indicator, debug source) presents a request
// and a 3-bit {r,g,b} colour. Grant is held for at least HOLD_TICKS cycles, then rotated fairly.
// Sits between the colour-producing state machines and the board LED pins.
// PARAMETERS
// N_REQ       4     number of requesters (>=2)
// HOLD_TICKS  1000  minimum cycles a grant is held before rotation (>=1)
// PWM_BITS    8     brightness counter/duty width (used only when LED_PWM_EN defined)
// PORTS
// clk    in   1          system clock, all logic on posedge
// rst    in   1          synchronous reset, active-low (rst==0 resets on posedge clk)
// req    in   N_REQ      request per requester, level-sensitive
// color  in   3*N_REQ    colour of requester i at [3*i+2:3*i] = {r,g,b}
// gnt    out  N_REQ      registered one-hot grant, all-zero when idle
// red    out  1          LED red drive
// green  out  1          LED green drive
// blue   out  1          LED blue drive
// busy   out  1          1 when any grant active (gnt != 0)
// BEHAVIOUR
// - Reset (rst==0): gnt=0, busy=0, red/green/blue=0, hold counter=0, state=IDLE,
//   last-owner pointer=N_REQ-1 (so first search starts at requester 0). Reset mid-grant aborts it.
// - States: IDLE (no owner), HOLD (owner, counter < HOLD_TICKS-1), OPEN (owner, hold expired).
// - Round-robin search: first asserted req starting at last_owner+1, wrapping modulo N_REQ.
// - IDLE: any req -> grant winner at next edge, counter=0, -> HOLD. No req -> stay IDLE.
// - HOLD: counter increments each cycle; owner kept regardless of other reqs.
//   At counter==HOLD_TICKS-1 -> OPEN next edge. HOLD_TICKS==1 goes straight to OPEN.
// - OPEN: other req pending -> grant next RR winner at next edge, counter=0, -> HOLD.
//   Only owner requesting -> keep grant, stay OPEN (no re-arbitration).
// - Owner deasserts req (HOLD or OPEN): release at next edge; grant RR winner among
//   remaining reqs (-> HOLD, counter=0) or gnt=0 (-> IDLE). No dead cycle between owners.
// - Simultaneous release + new reqs: resolved in same cycle by RR search, owner excluded.
// - last_owner updates whenever a new grant is issued; unchanged on transition to IDLE.
// - Counter width $clog2(HOLD_TICKS+1); saturates, never wraps.
// - gnt registered: 1-cycle latency from req to gnt. LED pins combinational from gnt and
//   color bus of owner (track owner colour changes same cycle); all 0 when gnt==0.
// - busy = |gnt. gnt always one-hot or zero.
// CONFIGURATION
// LED_PWM_EN defined: adds input duty[PWM_BITS-1:0]; free-running PWM_BITS counter
//   (reset to 0, wraps); each LED pin = owner colour bit AND (pwm_cnt < duty).
//   duty=0 -> LEDs always off; duty=2**PWM_BITS-1 -> off 1 cycle per period.
// LED_PWM_EN undefined: no duty port, no counter; LED pins = owner colour bits directly.
// TESTING (N_REQ=4, HOLD_TICKS=4, LED_PWM_EN undefined unless noted)
// 1 rst=0 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, red=green=blue=0 throughout.
// 2 req=4'b0100, color[8:6]=3'b101 -> next cycle gnt=4'b0100, busy=1, red=1 green=0 blue=1;
//   held indefinitely while req[2] stays high alone.
// 3 From reset, req=4'b0101 steady -> gnt=0001 for 4 cycles, then 0100 for 4, then 0001.
// 4 req=4'b1111 steady -> gnt sequence 0001,0010,0100,1000,0001, each exactly 4 cycles.
// 5 Owner 0 drops req at hold cycle 2 with req[1]=1 -> gnt=0010 next edge; all reqs drop
//   -> gnt=0, LEDs 0 next edge.
// 6 rst=0 during HOLD of requester 3 -> gnt=0 next edge; after release with req=1111,
//   grant goes to requester 0. LED_PWM_EN, PWM_BITS=2, duty=2 -> owner bit high 2 of 4 cycles.

Source files
------------

// File: rtl/rgb_led_arbiter_if.sv
// Requester/LED-side bundle for rgb_led_arbiter.
// Define LED_PWM_EN to add the duty input and the PWM_BITS parameter.
interface rgb_led_arbiter_if #(
    parameter int N_REQ = 4
`ifdef LED_PWM_EN
  , parameter int PWM_BITS = 8
`endif
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] color;
    logic [N_REQ-1:0]   gnt;
    logic               red;
    logic               green;
    logic               blue;
    logic               busy;
`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] duty;

    modport master (
        output req, color, duty,
        input  gnt, red, green, blue, busy
    );
    modport slave (
        input  req, color, duty,
        output gnt, red, green, blue, busy
    );
`else
    modport master (
        output req, color,
        input  gnt, red, green, blue, busy
    );
    modport slave (
        input  req, color,
        output gnt, red, green, blue, busy
    );
`endif
endinterface

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one RGB LED between N_REQ requesters.
// Define LED_PWM_EN to gate the LED pins with a duty-cycle PWM.
module rgb_led_arbiter #(
    parameter int N_REQ      = 4,
    parameter int HOLD_TICKS = 1000
`ifdef LED_PWM_EN
  , parameter int PWM_BITS   = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    rgb_led_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    state_t         state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  last_q, last_d;

    logic [N_REQ-1:0] cand;
    logic           win_v;
    logic [IW-1:0]  win_idx;
    logic           grant_new;
    logic           own_req;
    logic [2:0]     own_col;
    logic           pwm_on;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // The owner is never a candidate; in IDLE gnt_q is zero anyway.
    always_comb begin
        cand    = bus.req & ~gnt_q;
        win_v   = 1'b0;
        win_idx = last_q;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!win_v && cand[(int'(last_q) + i) % N_REQ]) begin
                win_v   = 1'b1;
                win_idx = IW'((int'(last_q) + i) % N_REQ);
            end
        end
    end

    assign own_req = |(bus.req & gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_new = 1'b0;
        unique case (state_q)
            IDLE: grant_new = win_v;
            HOLD, OPEN: begin
                if (!own_req) begin
                    if (win_v) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (state_q == HOLD) begin
                    if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_LAST) state_d = OPEN;
                end else begin
                    grant_new = win_v;
                end
            end
            default: state_d = IDLE;
        endcase
        // A one-tick hold is already expired at the moment of granting.
        if (grant_new) begin
            gnt_d   = ONE << win_idx;
            last_d  = win_idx;
            cnt_d   = '0;
            state_d = (HOLD_TICKS == 1) ? OPEN : HOLD;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_q;

    always_ff @(posedge clk) begin
        if (!rst) pwm_q <= '0;
        else      pwm_q <= pwm_q + 1'b1;
    end

    assign pwm_on = (pwm_q < bus.duty);
`else
    assign pwm_on = 1'b1;
`endif

    // While a grant is active, last_q always names its owner.
    always_comb begin
        own_col   = bus.color[3*last_q +: 3];
        bus.gnt   = gnt_q;
        bus.busy  = |gnt_q;
        bus.red   = bus.busy & pwm_on & own_col[2];
        bus.green = bus.busy & pwm_on & own_col[1];
        bus.blue  = bus.busy & pwm_on & own_col[0];
    end
endmodule
